pipelined_adder: RTL and testbench

- Segmented, pipelined WIDTH-bit adder for wide operands where a single-cycle ripple add misses timing.
- Splits operands into SEG-bit slices and adds one slice per stage, passing the carry between stage registers.
- Result is modulo 2^WIDTH, the same arithmetic as the combinational basic_adder.
- Sits as a drop-in timing-closure replacement that feeds downstream accumulators through a valid/ready handshake.

---
 rtl/adder_pkg.sv | 18 +
 rtl/pipelined_adder_seg.sv | 14 +
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - slice arithmetic helpers shared by the adder blocks
package adder_pkg;

    function automatic int num_segments(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_width(input int width, input int seg, input int k);
        int w;
        if ((k + 1) * seg <= width) begin
            w = seg;
        end else begin
            w = width - k * seg;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipelined_adder_seg.sv
// rtl/pipelined_adder_seg.sv - combinational W-bit slice adder with carry in/out
module pipelined_adder_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_s,
    input  logic [W-1:0] b_s,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - segmented pipelined adder, optional top carry output under PIPELINED_ADDER_COUT_EN
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
`ifdef PIPELINED_ADDER_COUT_EN
    ,
    output logic             cout
`endif
);

    localparam int STAGES = num_segments(WIDTH, SEG);

    // Per-stage state: valid bit, accumulated low result, carry out of the
    // slice just added, and a copy of the operands for the slices still ahead.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic             c_q [STAGES];

    // A single stall freezes every stage, bubbles included, so o holds until taken.
    logic stall;
    assign stall    = v_q[STAGES-1] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int SW = seg_width(WIDTH, SEG, k);

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] r_in;
        logic [WIDTH-1:0] r_next;
        logic [SW-1:0]    s;
        logic             co;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = b;
            assign r_in = '0;
            assign c_in = 1'b0;
        end else begin : g_body
            assign v_in = v_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign r_in = r_q[k-1];
            assign c_in = c_q[k-1];
        end

        pipelined_adder_seg #(
            .W(SW)
        ) u_seg (
            .a_s  (a_in[LO +: SW]),
            .b_s  (b_in[LO +: SW]),
            .cin  (c_in),
            .s    (s),
            .cout (co)
        );

        // Splice this stage's slice sum into the result carried from upstream.
        always_comb begin
            r_next            = r_in;
            r_next[LO +: SW]  = s;
        end

        // Stage register: clear on reset, advance whenever the pipe is not stalled.
        // The top-stage carry has no reader unless cout is built, so it is pruned then.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                r_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (!stall) begin
                v_q[k] <= v_in;
                r_q[k] <= r_next;
                a_q[k] <= a_in;
                b_q[k] <= b_in;
                c_q[k] <= co;
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign o         = r_q[STAGES-1];

`ifdef PIPELINED_ADDER_COUT_EN
    assign cout = c_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (16/4 and 10/4 builds)
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, o16;
    logic        iv10, ir10, ov10, or10;
    logic [9:0]  a10, b10, o10;
`ifdef PIPELINED_ADDER_COUT_EN
    logic        c16, c10;
`endif

    pipelined_adder #(.WIDTH(16), .SEG(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .o(o16)
`ifdef PIPELINED_ADDER_COUT_EN
        , .cout(c16)
`endif
    );

    pipelined_adder #(.WIDTH(10), .SEG(4)) u10 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10),
        .a(a10), .b(b10), .out_valid(ov10), .out_ready(or10), .o(o10)
`ifdef PIPELINED_ADDER_COUT_EN
        , .cout(c10)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: full-precision sums of accepted operands, in order.
    logic [16:0] q16 [$];
    logic [10:0] q10 [$];
    int cyc, first16, last16, cnt16, first10, last10, cnt10;

    typedef struct {
        bit          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        c;
        int          lat;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        logic [16:0] e16;
        logic [10:0] e10;
        @(negedge clk);
        if (ov16 && or16) begin
            n_vec++;
            if (q16.size() == 0) begin
                n_err++;
                $display("FAIL o16 spurious: got 0x%0h, expected no output", o16);
            end else begin
                n_vec--;
                e16 = q16.pop_front();
                check("o16 stream", o16, e16[15:0]);
`ifdef PIPELINED_ADDER_COUT_EN
                check("cout16 stream", c16, e16[16]);
`endif
                if (cnt16 == 0) first16 = cyc;
                last16 = cyc;
                cnt16++;
            end
        end
        if (ov10 && or10) begin
            n_vec++;
            if (q10.size() == 0) begin
                n_err++;
                $display("FAIL o10 spurious: got 0x%0h, expected no output", o10);
            end else begin
                n_vec--;
                e10 = q10.pop_front();
                check("o10 stream", o10, e10[9:0]);
`ifdef PIPELINED_ADDER_COUT_EN
                check("cout10 stream", c10, e10[10]);
`endif
                if (cnt10 == 0) first10 = cyc;
                last10 = cyc;
                cnt10++;
            end
        end
        if (iv16 && ir16) q16.push_back({1'b0, a16} + {1'b0, b16});
        if (iv10 && ir10) q10.push_back({1'b0, a10} + {1'b0, b10});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_one(input string name, input bit sel, input logic [15:0] av,
                           input logic [15:0] bv, input logic [15:0] ex, input logic exc,
                           input int lat);
        int n;
        n = 0;
        if (!sel) begin
            check({name, " in_ready"}, ir16, 1);
            a16 = av; b16 = bv; iv16 = 1'b1;
            tick();
            iv16 = 1'b0;
            while (!ov16 && n < 20) begin tick(); n++; end
            check({name, " latency"}, n, lat);
            check({name, " o"}, o16, ex);
`ifdef PIPELINED_ADDER_COUT_EN
            check({name, " cout"}, c16, exc);
`endif
        end else begin
            check({name, " in_ready"}, ir10, 1);
            a10 = av[9:0]; b10 = bv[9:0]; iv10 = 1'b1;
            tick();
            iv10 = 1'b0;
            while (!ov10 && n < 20) begin tick(); n++; end
            check({name, " latency"}, n, lat);
            check({name, " o"}, o10, ex);
`ifdef PIPELINED_ADDER_COUT_EN
            check({name, " cout"}, c10, exc);
`endif
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int n;

        tbl[0]  = '{1'b0, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 3};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3};
        tbl[2]  = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3};
        tbl[3]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3};
        tbl[4]  = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3};
        tbl[5]  = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 3};
        tbl[6]  = '{1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 3};
        tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3};
        tbl[8]  = '{1'b1, 16'h03FF, 16'h0001, 16'h0000, 1'b1, 2};
        tbl[9]  = '{1'b1, 16'h0155, 16'h00AA, 16'h01FF, 1'b0, 2};
        tbl[10] = '{1'b1, 16'h000F, 16'h0001, 16'h0010, 1'b0, 2};
        tbl[11] = '{1'b1, 16'h0200, 16'h0300, 16'h0100, 1'b1, 2};

        rst_n = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        iv10 = 1'b0; a10 = '0; b10 = '0; or10 = 1'b1;
        cyc = 0; cnt16 = 0; cnt10 = 0; first16 = -1; last16 = -1; first10 = -1; last10 = -1;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset out_valid16", ov16, 0);
        check("reset o16", o16, 0);
        check("reset in_ready16", ir16, 1);
        check("reset out_valid10", ov10, 0);
        check("reset o10", o10, 0);
        check("reset in_ready10", ir10, 1);
`ifdef PIPELINED_ADDER_COUT_EN
        check("reset cout16", c16, 0);
`endif
        tick();

        // Exact latency: 16-bit valid only after edge 3, 10-bit only after edge 2
        a16 = 16'h1234; b16 = 16'h0FED; iv16 = 1'b1;
        a10 = 10'h3FF;  b10 = 10'h001;  iv10 = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            iv16 = 1'b0; iv10 = 1'b0;
            check($sformatf("lat16 valid e%0d", e), ov16, (e == 3));
            check($sformatf("lat10 valid e%0d", e), ov10, (e == 2));
            if (e == 3) check("lat16 o", o16, 16'h2221);
            if (e == 2) check("lat10 o", o10, 10'h000);
        end
        tick();

        // Directed vector table
        for (int i = 0; i < 12; i++)
            run_one($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b,
                    tbl[i].exp, tbl[i].c, tbl[i].lat);

        // Streaming: 1000 random 16-bit pairs, 500 random 10-bit pairs, back to back
        cyc = 0;
        for (int i = 0; i < 1008; i++) begin
            iv16 = (i < 1000); a16 = 16'($urandom); b16 = 16'($urandom);
            iv10 = (i < 500);  a10 = 10'($urandom); b10 = 10'($urandom);
            step();
        end
        iv16 = 1'b0; iv10 = 1'b0;
        check("stream16 count", cnt16, 1000);
        check("stream16 first", first16, 4);
        check("stream16 last", last16, 1003);
        check("stream10 count", cnt10, 500);
        check("stream10 first", first10, 3);
        check("stream10 last", last10, 502);
        check("stream16 leftover", q16.size(), 0);
        check("stream10 leftover", q10.size(), 0);

        // Backpressure: hold out_ready low three cycles with a result pending
        iv16 = 1'b1;
        n = 0;
        while (!ov16 && n < 20) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            step();
            n++;
        end
        check("bp result pending", ov16, 1);
        held = o16;
        or16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            step();
            check($sformatf("bp out_valid c%0d", i), ov16, 1);
            check($sformatf("bp o held c%0d", i), o16, held);
            check($sformatf("bp in_ready c%0d", i), ir16, 0);
        end
        or16 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            step();
        end
        iv16 = 1'b0;
        repeat (10) step();
        check("bp drained", q16.size(), 0);
        check("bp idle", ov16, 0);

        // Reset mid-flight: three in flight, none may emit
        iv16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            step();
        end
        iv16 = 1'b0;
        rst_n = 1'b0;
        tick();
        q16.delete();
        q10.delete();
        check("midreset out_valid", ov16, 0);
        rst_n = 1'b1;
        check("midreset in_ready", ir16, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("midreset quiet c%0d", i), ov16, 0);
        end
        run_one("post-reset", 1'b0, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
